// File: rtl/mtree_accum_ctrl.sv
// mtree_accum_ctrl: streams chunks of 2^LEVELS elements through one shared adder
// tree and accumulates the per-chunk sums into a wide job total.
// Optional feature macro: MTREE_ACC_SAT_EN (accumulator saturates instead of wrapping).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, num_chunks   job launch (honoured only when idle) and chunk count
//   in_valid/in_ready   chunk stream handshake, in_data element n at [n]
//   out_valid/out_ready result handshake, out_sum holds the job total
//   busy                high whenever a job is in progress or its result is pending

// mtree: combinational pairwise adder tree, sum wraps modulo 2^IN_WIDTH.
module mtree #(
    parameter int IN_WIDTH = 32,
    parameter int LEVELS   = 4
) (
    input  logic [2**LEVELS-1:0][IN_WIDTH-1:0] data,
    output logic [IN_WIDTH-1:0]                sum
);
    localparam int N = 2**LEVELS;

    // Each pass halves the live width; t[k] is overwritten only after t[2k], t[2k+1] are read.
    function automatic logic [IN_WIDTH-1:0] reduce(input logic [N-1:0][IN_WIDTH-1:0] d);
        logic [N-1:0][IN_WIDTH-1:0] t;
        t = d;
        for (int w = N / 2; w > 0; w = w / 2)
            for (int k = 0; k < w; k++)
                t[k] = t[2*k] + t[2*k+1];
        return t[0];
    endfunction

    assign sum = reduce(data);
endmodule

module mtree_accum_ctrl #(
    parameter int IN_WIDTH  = 32,
    parameter int LEVELS    = 4,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16,
    localparam int NUM_INPUTS = 2**LEVELS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [CNT_WIDTH-1:0]                 num_chunks,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_INPUTS-1:0][IN_WIDTH-1:0]  in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ACC_WIDTH-1:0]                 out_sum,
    output logic                                 busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                              state;
    logic [NUM_INPUTS-1:0][IN_WIDTH-1:0] chunk_q;
    logic                                chunk_v;
    logic [ACC_WIDTH-1:0]                acc;
    logic [ACC_WIDTH-1:0]                acc_next;
    logic [CNT_WIDTH-1:0]                remaining;
    logic [IN_WIDTH-1:0]                 tree_sum;
    logic                                accept;

    mtree #(.IN_WIDTH(IN_WIDTH), .LEVELS(LEVELS)) u_tree (
        .data (chunk_q),
        .sum  (tree_sum)
    );

    assign accept  = in_valid && in_ready;
    assign out_sum = acc;

`ifdef MTREE_ACC_SAT_EN
    // One extra bit catches the carry; once pinned at all-ones every further add carries too.
    logic [ACC_WIDTH:0] acc_wide;
    assign acc_wide = {1'b0, acc} + (ACC_WIDTH+1)'(tree_sum);
    assign acc_next = acc_wide[ACC_WIDTH] ? '1 : acc_wide[ACC_WIDTH-1:0];
`else
    assign acc_next = acc + ACC_WIDTH'(tree_sum);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            chunk_q   <= '0;
            chunk_v   <= 1'b0;
            acc       <= '0;
            remaining <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            chunk_v <= 1'b0;
            if (chunk_v) acc <= acc_next;
            case (state)
                IDLE: if (start) begin
                    acc       <= '0;
                    remaining <= num_chunks;
                    busy      <= 1'b1;
                    if (num_chunks != '0) begin
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                ACCUM: if (accept) begin
                    chunk_q   <= in_data;
                    chunk_v   <= 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_WIDTH'(1)) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                // The last chunk's tree sum lands in acc on this edge.
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
